fifo_wr_arbiter: RTL

- Shares the single write port of the asynchronous FIFO (W_INC / WR_DATA / FULL) between NUM_REQ requesters in the write clock domain.
- Uses round-robin arbitration with a per-owner burst lock of up to BURST_MAX consecutive words, so short packets from one source are not interleaved.
- Never writes while FULL is high.
- Provides transfer and back-pressure statistics counters.

---
 rtl/fifo_wr_arbiter_if.sv | 23 ++
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle shared by the requesters, the arbiter and the async FIFO write side.
// The master side is the arbiter; the slave side is the requesters plus the FIFO.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ack;
   logic                          full;
   logic                          w_inc;
   logic [DATA_WIDTH-1:0]         wr_data;

   modport master (
      input  req_valid, req_data, full,
      output req_ack, w_inc, wr_data
   );

   modport slave (
      output req_valid, req_data, full,
      input  req_ack, w_inc, wr_data
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the FIFO write port, with a per-owner burst lock and
// saturating transfer/stall statistics. Write strobe is combinational from the requests.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_MAX  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       en_i,
   fifo_wr_arbiter_if.master          bus,
   output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
   output logic                       busy_o,
   output logic [CNT_WIDTH-1:0]       xfer_cnt_o,
   output logic [CNT_WIDTH-1:0]       stall_cnt_o
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(BURST_MAX + 1);

   typedef enum logic {IDLE, OWN} state_e;

   state_e               state_q, state_d;
   logic [IW-1:0]        owner_q, owner_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]        grant_q, grant_d;
   logic [BW-1:0]        burst_q, burst_d;
   logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
   logic [CNT_WIDTH-1:0] stall_q, stall_d;

   logic [IW-1:0] search_start, search_idx, cand;
   logic          own_hold, released, found, cand_valid, fire;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : IW'(int'(idx) + 1);
   endfunction

   // A locked owner that drops its request hands the port over in the same cycle.
   assign own_hold     = (state_q == OWN) &&  bus.req_valid[owner_q];
   assign released     = (state_q == OWN) && !bus.req_valid[owner_q];
   assign search_start = released ? wrap_inc(owner_q) : rr_ptr_q;

   always_comb begin : rr_search
      int idx;
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      found      = 1'b0;
      search_idx = '0;
      idx        = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(search_start) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && bus.req_valid[idx]) begin
            found      = 1'b1;
            search_idx = IW'(idx);
         end
      end
   end

   assign cand       = own_hold ? owner_q : search_idx;
   assign cand_valid = own_hold | found;
   assign fire       = rst_ni & en_i & ~bus.full & cand_valid;

   always_comb begin : port_drive
      bus.req_ack = '0;
      bus.w_inc   = fire;
      bus.wr_data = '0;
      if (fire) begin
         bus.req_ack[cand] = 1'b1;
         bus.wr_data       = bus.req_data[int'(cand)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin : next_state
      state_d  = state_q;
      owner_d  = owner_q;
      burst_d  = burst_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      xfer_d   = xfer_q;
      stall_d  = stall_q;

      if (fire) begin
         grant_d = cand;
         if (!(&xfer_q)) xfer_d = xfer_q + CNT_WIDTH'(1);
         if (own_hold) begin
            burst_d = burst_q + BW'(1);
            if (int'(burst_q) + 1 == BURST_MAX) begin
               state_d  = IDLE;
               rr_ptr_d = wrap_inc(owner_q);
            end
         end else begin
            owner_d = cand;
            burst_d = BW'(1);
            if (BURST_MAX == 1) begin
               state_d  = IDLE;
               rr_ptr_d = wrap_inc(cand);
            end else begin
               state_d = OWN;
            end
         end
      end else if (en_i && released) begin
         // Lock dropped but nobody could be served: rotation resumes after the old owner.
         state_d  = IDLE;
         rr_ptr_d = wrap_inc(owner_q);
      end

      if (en_i && bus.full && (|bus.req_valid) && !(&stall_q))
         stall_d = stall_q + CNT_WIDTH'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         burst_q  <= '0;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         xfer_q   <= '0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         burst_q  <= burst_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         xfer_q   <= xfer_d;
         stall_q  <= stall_d;
      end
   end

   assign grant_id_o  = grant_q;
   assign busy_o      = (state_q == OWN);
   assign xfer_cnt_o  = xfer_q;
   assign stall_cnt_o = stall_q;
endmodule
